ram_scramble_ctrl: RTL
======================

// Module: ram_scramble_ctrl
// PURPOSE
//  Front-end between the CPU memory bus and the main single-port RAM. Applies
//  the address randomisation (ram_aslr) and data scrambling (ram_scramble) set
//  by the tk1 core. After every reset it zero-wipes the whole physical RAM
//  before serving any access. Sits directly downstream of tk1's ram_aslr and
//  ram_scramble outputs; drives a synchronous RAM macro with 1-cycle read latency.
// PARAMETERS
//  AW        15  word-address width (2^AW 32-bit words; 15 -> 128 KiB)
//  WIPE_EN    1  1: run the wipe sweep after reset; 0: go straight to IDLE (sim only)
// PORTS
//  clk           in   1   system clock
//  reset_n       in   1   reset, asynchronous assert, active low
//  ram_aslr      in   AW  address XOR mask from tk1
//  ram_scramble  in   32  data key from tk1
//  cs            in   1   bus request, held high until ready
//  we            in   4   byte write enables; 4'h0 = read
//  address       in   AW  logical word address
//  write_data    in   32  write data
//  read_data     out  32  descrambled read data, valid while ready=1
//  ready         out  1   one-cycle completion pulse
//  wipe_done     out  1   high once the post-reset wipe has finished
//  mem_cs        out  1   RAM macro enable
//  mem_we        out  4   RAM byte write enables
//  mem_addr      out  AW  physical word address
//  mem_wdata     out  32  scrambled write data
//  mem_rdata     in   32  RAM read data, valid the cycle after mem_cs with mem_we=0
// BEHAVIOUR
//  - One clock domain. Reset is asynchronous and active low.
//  - Reset values: read_data=0, ready=0, wipe_done=0, mem_cs=0, mem_we=0,
//    mem_addr=0, mem_wdata=0. State goes to WIPE (or IDLE if WIPE_EN=0), wipe_ctr=0.
//  - Mapping, with key/addr sampled at request accept:
//    phys = address ^ ram_aslr.
//    key  = ram_scramble ^ {2'b00, address[14:0], address[14:0]} (logical address; for AW<15 zero-extend).
//    mem_wdata = write_data ^ key. read_data = mem_rdata ^ key.
//    The XOR is bytewise, so partial writes need no read-modify-write.
//  - FSM states: WIPE, IDLE, WRITE, RDWAIT.
//    WIPE: every cycle, mem_cs=1, mem_we=4'hf, mem_addr=wipe_ctr, mem_wdata=0.
//      wipe_ctr increments each cycle. At wipe_ctr == 2^AW-1 the FSM goes to IDLE
//      and wipe_done=1; wipe_done then stays high until the next reset.
//      cs is ignored and ready stays 0, so the CPU stalls.
//      Wipe length is exactly 2^AW cycles.
//    IDLE: cs with we!=0 -> drive the write to mem this cycle, go to WRITE.
//      cs with we==0 -> drive the read this cycle and register key, go to RDWAIT.
//    WRITE: ready=1 for one cycle -> IDLE. Write latency: ready at T+1.
//    RDWAIT: read_data = mem_rdata ^ key_reg, ready=1 for one cycle -> IDLE.
//      Read latency: ready at T+1.
//  - After ready, the FSM is always in IDLE. If cs is still high in the next cycle,
//    that is a new request (the bus master drops cs after ready).
//  - A change of ram_aslr/ram_scramble while a request is in flight does not
//    affect that request; it applies from the next accepted request.
//  - Wiped memory reads back as key, not 0 (raw zeros are descrambled). This is intended.
//  - mem_cs=0 and mem_we=0 in WRITE, RDWAIT and IDLE-without-cs.
//  - reset_n low at any time, including mid-wipe or mid-read: immediate return
//    to reset values. The wipe restarts from 0.
// STRUCTURE
//  - Shared package tk1_pkg: RAM_AW=15, state encoding localparams
//    (WIPE=2'd0, IDLE=2'd1, WRITE=2'd2, RDWAIT=2'd3), scramble key function.
//  - One sub-module, ram_scramble_key: combinational key/address mapping.
//    It is reused by the bench's reference model.
//  - Everything else (FSM, wipe counter, key register) is in this file.
// TESTING
//  1. Release reset with AW=15, WIPE_EN=1 and cs held high.
//     -> ready=0 and wipe_done=0 for exactly 32768 cycles.
//     -> mem_addr sweeps 0..0x7fff with mem_wdata=0, then wipe_done=1.
//  2. aslr=0x1234, scramble=0xdeadbeef; write address 0x0005 with 0x01020304, we=4'hf.
//     -> mem_addr=0x1231, mem_wdata=0x01020304^0xdeadbeef^0x00028005.
//     -> ready one cycle later.
//  3. Read back address 0x0005. -> ready at T+1, read_data=0x01020304.
//     Then write byte we=4'b0010 with data 0x0000aa00, read back -> 0x0102aa04.
//  4. Change ram_scramble to 0 during RDWAIT. -> the in-flight read still returns
//     the correct data; the next read of the same word returns scrambled garbage.
//  5. Pull reset_n low mid-wipe at wipe_ctr=0x100, and again in RDWAIT.
//     -> all outputs are 0 asynchronously; after release the wipe restarts at
//     addr 0 and runs the full 32768 cycles.
//  6. Read an untouched word after the wipe with scramble=0, aslr=0.
//     -> read_data = {2'b00, addr, addr}.

Source files
------------

// File: rtl/tk1_pkg.sv
// Shared tk1 definitions: RAM geometry, scramble-controller state encoding and key function.
// Pure declarations, no logic.
package tk1_pkg;

  localparam int RAM_AW = 15;

  typedef enum logic [1:0] {
    WIPE   = 2'd0,
    IDLE   = 2'd1,
    WRITE  = 2'd2,
    RDWAIT = 2'd3
  } ram_state_t;

  // Key depends on the logical address so identical plaintext differs per word.
  function automatic logic [31:0] scramble_key(input logic [31:0] scramble,
                                               input logic [14:0] laddr);
    return scramble ^ {2'b00, laddr, laddr};
  endfunction

endpackage

// File: rtl/ram_scramble_key.sv
// Combinational logical->physical address and data key mapping.
// Zero latency; no flow control.
import tk1_pkg::*;

module ram_scramble_key #(
  parameter int AW = RAM_AW
) (
  input  logic [AW-1:0] address,
  input  logic [AW-1:0] ram_aslr,
  input  logic [31:0]   ram_scramble,
  output logic [AW-1:0] phys,
  output logic [31:0]   key
);

  logic [14:0] laddr;

  generate
    if (AW >= 15) begin : g_wide
      assign laddr = address[14:0];
    end else begin : g_narrow
      assign laddr = {{(15-AW){1'b0}}, address};
    end
  endgenerate

  assign phys = address ^ ram_aslr;
  assign key  = scramble_key(ram_scramble, laddr);

endmodule

// File: rtl/ram_scramble_ctrl.sv
// CPU-bus front end for the main RAM: address randomisation, data scrambling, post-reset wipe.
// Read and write complete with ready one cycle after accept; CPU stalls (ready=0) during the wipe.
import tk1_pkg::*;

module ram_scramble_ctrl #(
  parameter int AW      = RAM_AW,
  parameter bit WIPE_EN = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] ram_aslr,
  input  logic [31:0]   ram_scramble,
  input  logic          cs,
  input  logic [3:0]    we,
  input  logic [AW-1:0] address,
  input  logic [31:0]   write_data,
  output logic [31:0]   read_data,
  output logic          ready,
  output logic          wipe_done,
  output logic          mem_cs,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [AW-1:0] WIPE_LAST   = '1;
  localparam ram_state_t    RESET_STATE = WIPE_EN ? WIPE : IDLE;

  ram_state_t    state;
  logic [AW-1:0] wipe_ctr;
  logic [AW-1:0] phys;
  logic [31:0]   key;
  logic [31:0]   key_reg;

  ram_scramble_key #(.AW(AW)) u_key (
    .address      (address),
    .ram_aslr     (ram_aslr),
    .ram_scramble (ram_scramble),
    .phys         (phys),
    .key          (key)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RESET_STATE;
      wipe_ctr  <= '0;
      wipe_done <= 1'b0;
      key_reg   <= '0;
    end else begin
      case (state)
        WIPE: begin
          wipe_ctr <= wipe_ctr + 1'b1;
          if (wipe_ctr == WIPE_LAST) begin
            state     <= IDLE;
            wipe_done <= 1'b1;
          end
        end
        IDLE: begin
          wipe_done <= 1'b1;
          if (cs) begin
            // Key is captured here so a key change mid-read cannot corrupt it.
            key_reg <= key;
            state   <= (we != 4'h0) ? WRITE : RDWAIT;
          end
        end
        WRITE:   state <= IDLE;
        RDWAIT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_cs    = 1'b0;
    mem_we    = 4'h0;
    mem_addr  = '0;
    mem_wdata = '0;
    read_data = '0;
    ready     = 1'b0;
    case (state)
      WIPE: begin
        // Reset parks the FSM in WIPE; keep the macro quiet while reset is held.
        if (reset_n) begin
          mem_cs   = 1'b1;
          mem_we   = 4'hf;
          mem_addr = wipe_ctr;
        end
      end
      IDLE: begin
        if (cs) begin
          mem_cs   = 1'b1;
          mem_we   = we;
          mem_addr = phys;
          if (we != 4'h0) mem_wdata = write_data ^ key;
        end
      end
      WRITE:  ready = 1'b1;
      RDWAIT: begin
        ready     = 1'b1;
        read_data = mem_rdata ^ key_reg;
      end
      default: ;
    endcase
  end

endmodule
